toggle_counter: RTL and testbench
=================================

# toggle_counter

Parametrised synchronous counter built from a bank of toggle cells; the multi-bit, mode-selectable successor to the single toggle flip-flop. It provides up/down counting, parallel load, a programmable modulus, and wrap, saturate or one-shot terminal behaviour. It is the standard counting primitive for dividers, timers and event counters in the design.

## Interface
- `WIDTH`, 8: counter width in bits (≥ 2).
- `MAX_COUNT`, 2**WIDTH-1: highest count value; the counter spans 0..MAX_COUNT (must be ≥ 1 and ≤ 2**WIDTH-1).
- `RESET_VALUE`, 0: value of `count` after reset (must be ≤ MAX_COUNT).
- `clk`  in  1  clock; every state change happens on the rising edge.
- `reset`  in  1  synchronous, active-high reset; highest priority.
- `load`  in  1  synchronous parallel load strobe.
- `load_value`  in  WIDTH  value loaded when `load`=1.
- `en`  in  1  count enable; one step per cycle while high.
- `dir`  in  1  1 = count up, 0 = count down.
- `mode`  in  2  00 = wrap, 01 = saturate, 10 = one-shot, 11 = treated as wrap.
- `count`  out  WIDTH  current count (registered).
- `tc`  out  1  terminal-count pulse (registered, one cycle).
- `done`  out  1  one-shot completion flag (registered, sticky).

## Operation
- Priority per edge: `reset` > `load` > counting step (`en`=1 and not halted) > hold.
- Reset: `count`←RESET_VALUE, `tc`←0, `done`←0.
- Load: `count`←min(`load_value`, MAX_COUNT), `tc`←0, `done`←0. Load ignores `en`, `dir` and `mode`.
- Counting step, up direction:
  - count < MAX_COUNT: count+1.
  - count = MAX_COUNT, wrap mode: count←0 and `tc`=1.
  - count = MAX_COUNT, saturate mode: hold and `tc`=1.
  - count = MAX_COUNT, one-shot mode: hold, `tc`=1, `done`←1.
- Counting step, down direction: mirror of the up direction. Terminal value is 0, and the wrap target is MAX_COUNT.
- Halt: while `done`=1, counting steps are suppressed regardless of `en`. Only `reset` or `load` clears `done`.
- `tc` is 0 in every cycle that is not a terminal step. While held in saturate mode with `en`=1, `tc` asserts on every enabled edge.
- A direction change at a terminal value is legal. For example, at count=0 with `dir`=1, the counter steps to 1 and `tc` stays 0.
- A `mode` change takes effect on the next edge. No mode change affects `done` except through one-shot completion.
- Arithmetic is modulo MAX_COUNT+1. When MAX_COUNT < 2**WIDTH-1, values above MAX_COUNT are never produced.

## Timing
- Latency is one cycle: inputs sampled at edge N appear on `count`, `tc` and `done` after edge N.
- All outputs are registered. There is no combinational path from any input to any output.
- `tc` is high for exactly the cycle following the terminal edge, together with the wrapped or held `count`.
- After a reset released at edge N, the first counting step can occur at edge N+1.
- Reset mid-count or mid-one-shot aborts immediately with no pending `tc`.
- `load` and `en` together: load wins, and no step occurs that cycle.

## Structure
- Shared package `counter_pkg`:
  - mode enumeration `CNT_WRAP`, `CNT_SAT`, `CNT_ONESHOT`.
  - direction constants `CNT_UP` and `CNT_DOWN`.
- Sub-module `toggle_cell`: one bit with synchronous active-high reset to a per-bit reset value, synchronous load, and toggle input.
- The top level generates WIDTH cells and computes each toggle term. For up counting, a bit toggles when all lower bits are 1; for down counting, when all lower bits are 0.
- Terminal detection and the wrap/saturate override are applied as load operations on the cell bank.
- `tc` and `done` are flops in the top level.

## Test plan
All scenarios use WIDTH=4, MAX_COUNT=9, RESET_VALUE=0.
- **Reset and wrap up:** reset, then `en`=1, `dir`=1, mode=wrap for 12 cycles → count 1..9,0,1,2; `tc`=1 only in the cycle count shows 0.
- **Saturate down:** load 2, then `dir`=0, mode=saturate, `en`=1 for 5 cycles → count 1,0,0,0,0; `tc`=0,0,1,1,1.
- **One-shot:** load 7, then `dir`=1, mode=one-shot, `en`=1 for 5 cycles → count 8,9,9,9,9; `tc` pulses once with 9; `done`=1 and stays 1. A following load 3 → count 3, `done`=0.
- **Priority and clamp:** `load`=1 with `load_value`=15 and `en`=1 → count 9 (clamped), no step, `tc`=0. `reset`=1 with `load`=1 → count 0.
- **Direction reversal at terminal:** count 0, then `dir`=1, `en`=1 for 1 cycle → count 1, `tc`=0. Then `dir`=0 for 2 cycles → count 0, then 9 (wrap) with `tc`=1.
- **Reset mid-run:** counting up at count 5, assert `reset` for 1 cycle → count 0, `tc`=0, `done`=0; counting resumes on the next edge.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the toggle-cell counter family: terminal modes, direction values, mode decode.
// Latency: none, types and constant functions only.
// Backpressure: none.
package counter_pkg;

    // Terminal behaviour when a counting step lands on the terminal value.
    typedef enum logic [1:0] {
        CNT_WRAP    = 2'b00,
        CNT_SAT     = 2'b01,
        CNT_ONESHOT = 2'b10
    } cnt_mode_e;

    localparam logic CNT_UP   = 1'b1;
    localparam logic CNT_DOWN = 1'b0;

    // The unused encoding 2'b11 behaves as wrap.
    function automatic cnt_mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'b01:   return CNT_SAT;
            2'b10:   return CNT_ONESHOT;
            default: return CNT_WRAP;
        endcase
    endfunction

endpackage

// File: rtl/toggle_counter_if.sv
// Control and status bundle of toggle_counter: load/count controls in, count/tc/done out.
// Latency: n/a, wiring only. master = controlling block, slave = counter.
// Backpressure: none; the counter accepts a command every cycle.
interface toggle_counter_if #(
    parameter int WIDTH = 8
);
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             en;
    logic             dir;
    logic [1:0]       mode;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             done;

    modport master (
        output load, load_value, en, dir, mode,
        input  count, tc, done
    );

    modport slave (
        input  load, load_value, en, dir, mode,
        output count, tc, done
    );
endinterface

// File: rtl/toggle_cell.sv
// Single counter bit: sync active-high reset to RESET_BIT, then sync load of d, then toggle on t.
// Latency: one cycle, q changes on the rising edge after the controls are sampled.
// Backpressure: none. Ports: clk, reset, load, d, t in; q out.
module toggle_cell #(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic d,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RESET_BIT;
        end else if (load) begin
            q <= d;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/toggle_counter.sv
// Up/down counter over 0..MAX_COUNT built from toggle cells; wrap, saturate or one-shot at the terminal value.
// Latency: one cycle; count, tc and done are all registered, no input-to-output combinational path.
// Backpressure: none. Ports: clk, reset (sync, active-high), bus (toggle_counter_if.slave).
module toggle_counter
    import counter_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int MAX_COUNT   = 2**WIDTH - 1,
    parameter int RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             reset,
    toggle_counter_if.slave  bus
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VALUE);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] bank_d;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] up_chain;
    logic [WIDTH-1:0] dn_chain;
    logic             bank_load;
    logic             step;
    logic             at_term;
    logic             terminal;
    logic             tc_q;
    logic             done_q;
    cnt_mode_e        mode_d;

    assign mode_d       = decode_mode(bus.mode);
    assign load_clamped = (bus.load_value > MAX_V) ? MAX_V : bus.load_value;

    // A step needs enable, no competing load, and no completed one-shot.
    assign step     = bus.en && !bus.load && !done_q;
    assign at_term  = (bus.dir == CNT_UP) ? (cnt_q == MAX_V) : (cnt_q == '0);
    assign terminal = step && at_term;

    // Bit i toggles when all lower bits are 1 (up) or all lower bits are 0 (down).
    always_comb begin
        up_chain    = '0;
        dn_chain    = '0;
        up_chain[0] = 1'b1;
        dn_chain[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            up_chain[i] = up_chain[i-1] &  cnt_q[i-1];
            dn_chain[i] = dn_chain[i-1] & ~cnt_q[i-1];
        end
    end

    // Off-terminal steps never leave 0..MAX_COUNT, so plain toggling is safe there.
    assign toggle = (step && !at_term) ? ((bus.dir == CNT_UP) ? up_chain : dn_chain) : '0;

    // Terminal steps are handled as a bank load: wrap target, or the current value to hold.
    assign bank_load = bus.load || terminal;

    always_comb begin
        bank_d = cnt_q;
        if (bus.load) begin
            bank_d = load_clamped;
        end else if (mode_d == CNT_WRAP) begin
            bank_d = (bus.dir == CNT_UP) ? '0 : MAX_V;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        toggle_cell #(
            .RESET_BIT (RST_V[i])
        ) u_cell (
            .clk   (clk),
            .reset (reset),
            .load  (bank_load),
            .d     (bank_d[i]),
            .t     (toggle[i]),
            .q     (cnt_q[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tc_q   <= 1'b0;
            done_q <= 1'b0;
        end else if (bus.load) begin
            tc_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            tc_q <= terminal;
            if (terminal && mode_d == CNT_ONESHOT) begin
                done_q <= 1'b1;
            end
        end
    end

    assign bus.count = cnt_q;
    assign bus.tc    = tc_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_toggle_counter.sv
// Bench for toggle_counter (WIDTH=4, MAX_COUNT=9, RESET_VALUE=0): directed vector table, then random
// stimulus compared with an arithmetic reference model of the counting rules.
module tb_toggle_counter;

    localparam int W    = 4;
    localparam int MAXC = 9;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    toggle_counter_if #(.WIDTH(W)) cif ();

    toggle_counter #(
        .WIDTH       (W),
        .MAX_COUNT   (MAXC),
        .RESET_VALUE (0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (cif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       r;
        logic       l;
        logic [3:0] lv;
        logic       e;
        logic       d;
        logic [1:0] m;
        int         exp_count;
        logic       exp_tc;
        logic       exp_done;
    } vec_t;

    vec_t vecs[$];

    task automatic addv(input logic r, input logic l, input int lv, input logic e, input logic d,
                        input int m, input int c, input logic t, input logic dn);
        vec_t v;
        v.r = r; v.l = l; v.lv = 4'(lv); v.e = e; v.d = d; v.m = 2'(m);
        v.exp_count = c; v.exp_tc = t; v.exp_done = dn;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic l, input logic [3:0] lv, input logic e,
                         input logic d, input logic [1:0] m);
        reset          = r;
        cif.load       = l;
        cif.load_value = lv;
        cif.en         = e;
        cif.dir        = d;
        cif.mode       = m;
    endtask

    task automatic check(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    // Reference model state
    int   mc;
    logic mt;
    logic md;

    task automatic model_step(input logic r, input logic l, input int lv, input logic e,
                              input logic d, input int m);
        if (r) begin
            mc = 0; mt = 1'b0; md = 1'b0;
        end else if (l) begin
            mc = (lv > MAXC) ? MAXC : lv; mt = 1'b0; md = 1'b0;
        end else if (e && !md) begin
            mt = 1'b0;
            if (d ? (mc == MAXC) : (mc == 0)) begin
                mt = 1'b1;
                if (m == 2) md = 1'b1;
                else if (m != 1) mc = d ? 0 : MAXC;
            end else begin
                mc = d ? mc + 1 : mc - 1;
            end
        end else begin
            mt = 1'b0;
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0);

        // Reset then wrap up for 12 cycles
        addv(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 12; i++)
            addv(0, 0, 0, 1, 1, 0, i % 10, (i == 10), 0);
        // Saturate down
        addv(0, 1, 2, 0, 0, 0, 2, 0, 0);
        addv(0, 0, 0, 1, 0, 1, 1, 0, 0);
        addv(0, 0, 0, 1, 0, 1, 0, 0, 0);
        addv(0, 0, 0, 1, 0, 1, 0, 1, 0);
        addv(0, 0, 0, 1, 0, 1, 0, 1, 0);
        addv(0, 0, 0, 1, 0, 1, 0, 1, 0);
        // One-shot up, halt, then load clears done
        addv(0, 1, 7, 0, 1, 2, 7, 0, 0);
        addv(0, 0, 0, 1, 1, 2, 8, 0, 0);
        addv(0, 0, 0, 1, 1, 2, 9, 0, 0);
        addv(0, 0, 0, 1, 1, 2, 9, 1, 1);
        addv(0, 0, 0, 1, 1, 2, 9, 0, 1);
        addv(0, 0, 0, 1, 1, 0, 9, 0, 1);   // wrap mode does not release the halt
        addv(0, 1, 3, 0, 1, 2, 3, 0, 0);
        // Priority and clamp
        addv(0, 1, 15, 1, 1, 0, 9, 0, 0);
        addv(0, 1, 10, 1, 0, 0, 9, 0, 0);
        addv(1, 1, 5, 1, 1, 0, 0, 0, 0);
        // Direction reversal at terminal
        addv(0, 0, 0, 1, 1, 0, 1, 0, 0);
        addv(0, 0, 0, 1, 0, 0, 0, 0, 0);
        addv(0, 0, 0, 1, 0, 0, 9, 1, 0);
        // Mode 11 behaves as wrap
        addv(0, 0, 0, 1, 1, 3, 0, 1, 0);
        // Enable low holds, tc drops
        addv(0, 0, 0, 0, 1, 0, 0, 0, 0);
        // Reset mid-run, counting resumes on the next edge
        addv(0, 1, 4, 0, 1, 0, 4, 0, 0);
        addv(0, 0, 0, 1, 1, 0, 5, 0, 0);
        addv(1, 0, 0, 1, 1, 0, 0, 0, 0);
        addv(0, 0, 0, 1, 1, 0, 1, 0, 0);
        // Reset mid one-shot clears done
        addv(0, 1, 9, 0, 1, 2, 9, 0, 0);
        addv(0, 0, 0, 1, 1, 2, 9, 1, 1);
        addv(1, 0, 0, 1, 1, 2, 0, 0, 0);
        addv(0, 0, 0, 1, 0, 2, 0, 1, 1);

        @(posedge clk);
        #1;
        foreach (vecs[k]) begin
            drive(vecs[k].r, vecs[k].l, vecs[k].lv, vecs[k].e, vecs[k].d, vecs[k].m);
            @(posedge clk);
            #1;
            check("vec_count", k, int'(cif.count), vecs[k].exp_count);
            check("vec_tc",    k, int'(cif.tc),    int'(vecs[k].exp_tc));
            check("vec_done",  k, int'(cif.done),  int'(vecs[k].exp_done));
        end

        // Random phase, model resynchronised by an initial reset
        mc = 0; mt = 1'b0; md = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            logic       r, l, e, d;
            logic [3:0] lv;
            logic [1:0] m;
            r  = (n == 0) || ($urandom_range(0, 99) < 2);
            l  = ($urandom_range(0, 99) < 8);
            lv = 4'($urandom_range(0, 15));
            e  = ($urandom_range(0, 99) < 75);
            d  = ($urandom_range(0, 99) < 55);
            m  = 2'($urandom_range(0, 3));
            drive(r, l, lv, e, d, m);
            model_step(r, l, int'(lv), e, d, int'(m));
            @(posedge clk);
            #1;
            check("rnd_count", n, int'(cif.count), mc);
            check("rnd_tc",    n, int'(cif.tc),    int'(mt));
            check("rnd_done",  n, int'(cif.done),  int'(md));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
